// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM burst reader: FSM encoding,
// bus widths and the word-alignment helper.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] ADDR_STEP = 32'd4;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rom_reader_fifo.sv
// Synchronous output buffer holding read data plus its end-of-burst flag.
// Head entry is presented combinationally from the storage registers.
module rom_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests so the buffer can never under- or overflow.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == '0);

endmodule

// File: rtl/rom_reader.sv
// Burst reader: issues word reads to a fixed-latency memory port and streams
// the returned words out through a credit-limited output buffer.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic [31:0]       mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                state_r, state_s;
    logic [ADDR_W-1:0]     addr_r, addr_s;
    logic [15:0]           left_r, left_s;
    logic                  rd_r, rd_last_r;
    logic [RD_LATENCY-1:0] vld_sr_r, vld_sr_s;
    logic [RD_LATENCY-1:0] last_sr_r, last_sr_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  issue_s, issue_last_s;
    logic                  pop_s, push_s, credit_s;
    logic [CW:0]           pending_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  fifo_empty_s;
    logic [DATA_W:0]       fifo_head_s;

    assign pop_s  = !fifo_empty_s && m_ready;
    assign push_s = vld_sr_r[RD_LATENCY-1];

    // Reads already committed (buffered or still in the memory pipeline) gate new issues.
    always_comb begin
        pending_s = (CW+1)'(fifo_count_s) + (CW+1)'(rd_r);
        for (int i = 0; i < RD_LATENCY; i++) begin
            pending_s = pending_s + (CW+1)'(vld_sr_r[i]);
        end
        credit_s = pending_s < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop_s));
        vld_sr_s[0]  = rd_r;
        last_sr_s[0] = rd_last_r;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr_s[i]  = vld_sr_r[i-1];
            last_sr_s[i] = last_sr_r[i-1];
        end
    end

    // Next-state, read issue and handshake decisions.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        left_s       = left_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (word_count != 16'd0)) begin
                    state_s      = READ;
                    issue_s      = 1'b1;
                    issue_last_s = (word_count == 16'd1);
                    addr_s       = align_word(base_addr);
                    left_s       = word_count - 16'd1;
                    busy_s       = 1'b1;
                end else if (start) begin
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            READ: begin
                if ((left_r != 16'd0) && credit_s) begin
                    issue_s      = 1'b1;
                    issue_last_s = (left_r == 16'd1);
                    addr_s       = addr_r + ADDR_STEP;
                    left_s       = left_r - 16'd1;
                end else begin
                    issue_s = 1'b0;
                end
                if (left_s == 16'd0) begin
                    state_s = DRAIN;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (pop_s && fifo_head_s[DATA_W]) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Control state and memory-pipeline tag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            left_r    <= 16'd0;
            rd_r      <= 1'b0;
            rd_last_r <= 1'b0;
            vld_sr_r  <= '0;
            last_sr_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            left_r    <= left_s;
            rd_r      <= issue_s;
            rd_last_r <= issue_last_s;
            vld_sr_r  <= vld_sr_s;
            last_sr_r <= last_sr_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    rom_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({last_sr_r[RD_LATENCY-1], mem_dout}),
        .dout  (fifo_head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign busy     = busy_r;
    assign done     = done_r;
    assign mem_addr = addr_r;
    assign mem_we   = 4'b0000;
    assign mem_din  = 32'h0000_0000;
    assign m_valid  = !fifo_empty_s;
    assign m_data   = fifo_head_s[DATA_W-1:0];
    assign m_last   = !fifo_empty_s && fifo_head_s[DATA_W];

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: memory model returns the word address,
// expected streams are derived from base/count arithmetic.
module tb_rom_reader;

    localparam int RDL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [15:0] word_count = 16'h0;
    logic        busy, done, m_valid, m_last;
    logic        m_ready = 1'b0;
    logic [31:0] mem_addr, mem_din, mem_dout, m_data;
    logic [3:0]  mem_we;
    logic [31:0] mem_pipe [RDL];

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_data[$];
    logic        obs_last[$];
    int          obs_k[$];
    int first_valid_k, done_k, done_cnt, busy_high_cnt, busy_low_k, stab_viol, wr_viol;
    logic [31:0] end_addr;
    int          extra_k = -1;
    logic [31:0] extra_base;
    logic [15:0] extra_cnt;

    rom_reader #(.RD_LATENCY(RDL), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_pipe[0] <= mem_addr;
        for (int i = 1; i < RDL; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign mem_dout = mem_pipe[RDL-1];

    function automatic logic [31:0] exp_addr(input logic [31:0] b, input int i);
        return (b & 32'hFFFF_FFFC) + 32'(i * 4);
    endfunction

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = n;
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; word_count = 16'($urandom);
    endtask

    // Records observations only; k=0 is the cycle right after the start edge.
    task automatic collect(input int ncyc, input int mode);
        logic        hold;
        logic [31:0] hd;
        logic        hl;
        hold = 1'b0; hd = 32'h0; hl = 1'b0;
        obs_data.delete(); obs_last.delete(); obs_k.delete();
        first_valid_k = -1; done_k = -1; done_cnt = 0; busy_high_cnt = 0;
        busy_low_k = -1; stab_viol = 0; wr_viol = 0;
        for (int k = 0; k < ncyc; k++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (k == extra_k) begin
                start = 1'b1; base_addr = extra_base; word_count = extra_cnt;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (hold && (!m_valid || m_data !== hd || m_last !== hl)) stab_viol++;
            if (m_valid && first_valid_k < 0) first_valid_k = k;
            if (m_valid && m_ready) begin
                obs_data.push_back(m_data); obs_last.push_back(m_last); obs_k.push_back(k);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (busy === 1'b1) busy_high_cnt++;
            else if (busy_low_k < 0) busy_low_k = k;
            if (mem_we !== 4'h0 || mem_din !== 32'h0) wr_viol++;
            hold = m_valid && !m_ready; hd = m_data; hl = m_last;
            @(posedge clk); #1;
        end
        start = 1'b0;
        extra_k = -1;
        end_addr = mem_addr;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, m_valid, m_last} !== 4'b0000 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b last=%b addr=%h, want all 0",
                     busy, done, m_valid, m_last, mem_addr);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        collect(3, 0);
        checks++;
        if (first_valid_k != -1 || done_cnt != 0 || busy_high_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle: valid_k=%0d done=%0d busy=%0d, want -1/0/0",
                     first_valid_k, done_cnt, busy_high_cnt);
        end
    endtask

    task automatic test_basic;
        pulse_start(32'h4, 16'd3);
        collect(12, 0);
        checks++;
        if (obs_data.size() != 3) begin
            errors++; $display("FAIL basic_count: got %0d words want 3", obs_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < 3; i++) begin
            checks++;
            if (obs_data[i] !== exp_addr(32'h4, i) || obs_last[i] !== (i == 2) || obs_k[i] != RDL + 1 + i) begin
                errors++;
                $display("FAIL basic_word%0d: data=%h last=%b k=%0d want %h %b %0d", i, obs_data[i],
                         obs_last[i], obs_k[i], exp_addr(32'h4, i), (i == 2), RDL + 1 + i);
            end
        end
        checks++;
        if (done_k != RDL + 4 || done_cnt != 1 || busy_high_cnt != done_k || busy_low_k != done_k) begin
            errors++;
            $display("FAIL basic_done: done_k=%0d cnt=%0d busy_hi=%0d busy_lo=%0d want %0d 1 %0d %0d",
                     done_k, done_cnt, busy_high_cnt, busy_low_k, RDL + 4, RDL + 4, RDL + 4);
        end
        checks++;
        if (end_addr !== 32'hC || wr_viol != 0) begin
            errors++; $display("FAIL basic_addr: end=%h wr=%0d want 0000000c 0", end_addr, wr_viol);
        end
    endtask

    task automatic test_zero;
        logic [31:0] pre;
        pre = mem_addr;
        pulse_start(32'h40, 16'd0);
        collect(6, 0);
        checks++;
        if (done_k != 0 || done_cnt != 1 || busy_high_cnt != 0 || first_valid_k != -1 || end_addr !== pre) begin
            errors++;
            $display("FAIL zero_count: done_k=%0d cnt=%0d busy=%0d valid_k=%0d addr=%h want 0 1 0 -1 %h",
                     done_k, done_cnt, busy_high_cnt, first_valid_k, end_addr, pre);
        end
    endtask

    task automatic test_toggle;
        pulse_start(32'h1000, 16'd8);
        collect(40, 1);
        checks++;
        if (obs_data.size() != 8 || stab_viol != 0) begin
            errors++; $display("FAIL toggle_count: words=%0d stab=%0d want 8 0", obs_data.size(), stab_viol);
        end
        for (int i = 0; i < obs_data.size() && i < 8; i++) begin
            checks++;
            if (obs_data[i] !== exp_addr(32'h1000, i) || obs_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL toggle_word%0d: data=%h last=%b want %h %b", i, obs_data[i], obs_last[i],
                         exp_addr(32'h1000, i), (i == 7));
            end
        end
        checks++;
        if (obs_k.size() == 8 && (done_k != obs_k[7] + 1 || done_cnt != 1)) begin
            errors++; $display("FAIL toggle_done: done_k=%0d want %0d", done_k, obs_k[7] + 1);
        end
    endtask

    task automatic test_wrap;
        pulse_start(32'hFFFF_FFF8, 16'd4);
        collect(14, 0);
        checks++;
        if (obs_data.size() != 4 || end_addr !== 32'h4) begin
            errors++; $display("FAIL wrap_count: words=%0d end=%h want 4 00000004", obs_data.size(), end_addr);
        end
        for (int i = 0; i < obs_data.size() && i < 4; i++) begin
            checks++;
            if (obs_data[i] !== exp_addr(32'hFFFF_FFF8, i)) begin
                errors++;
                $display("FAIL wrap_word%0d: data=%h want %h", i, obs_data[i], exp_addr(32'hFFFF_FFF8, i));
            end
        end
    endtask

    task automatic test_reset_mid;
        pulse_start(32'h100, 16'd6);
        collect(RDL + 3, 0);
        checks++;
        if (obs_data.size() != 2) begin
            errors++; $display("FAIL rstmid_pre: words=%0d want 2", obs_data.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, m_valid, m_last} !== 4'b0000 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: busy=%b done=%b valid=%b last=%b addr=%h want 0",
                     busy, done, m_valid, m_last, mem_addr);
        end
        #4 rst = 1'b0;
        collect(10, 0);
        checks++;
        if (done_cnt != 0 || first_valid_k != -1 || busy_high_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: done=%0d valid_k=%0d busy=%0d want 0 -1 0",
                     done_cnt, first_valid_k, busy_high_cnt);
        end
        pulse_start(32'h10, 16'd2);
        collect(10, 0);
        checks++;
        if (obs_data.size() != 2 || obs_data[0] !== 32'h10 || obs_data[1] !== 32'h14 ||
            obs_last[1] !== 1'b1 || obs_last[0] !== 1'b0 || first_valid_k != RDL + 1 || done_k != RDL + 3) begin
            errors++;
            $display("FAIL rstmid_restart: words=%0d valid_k=%0d done_k=%0d want 2 words 10,14 %0d %0d",
                     obs_data.size(), first_valid_k, done_k, RDL + 1, RDL + 3);
        end
    endtask

    task automatic test_start_busy;
        extra_k = 2; extra_base = 32'h200; extra_cnt = 16'd3;
        pulse_start(32'h7, 16'd5);
        collect(24, 0);
        checks++;
        if (obs_data.size() != 5 || done_cnt != 1 || wr_viol != 0) begin
            errors++;
            $display("FAIL busy_start: words=%0d done=%0d wr=%0d want 5 1 0", obs_data.size(), done_cnt, wr_viol);
        end
        for (int i = 0; i < obs_data.size() && i < 5; i++) begin
            checks++;
            if (obs_data[i] !== exp_addr(32'h7, i)) begin
                errors++; $display("FAIL busy_word%0d: data=%h want %h", i, obs_data[i], exp_addr(32'h7, i));
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] b;
        int n, mode, last;
        for (int r = 0; r < 8; r++) begin
            b = $urandom; n = $urandom_range(1, 10); mode = (r % 2 == 0) ? 0 : 2;
            pulse_start(b, 16'(n));
            collect(4 * n + 20, mode);
            checks++;
            if (obs_data.size() != n || stab_viol != 0 || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_count: words=%0d stab=%0d done=%0d want %0d 0 1",
                         r, obs_data.size(), stab_viol, done_cnt, n);
                continue;
            end
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs_data[i] !== exp_addr(b, i) || obs_last[i] !== (i == n - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: data=%h last=%b want %h %b", r, i, obs_data[i],
                             obs_last[i], exp_addr(b, i), (i == n - 1));
                end
            end
            last = obs_k[n-1];
            checks++;
            if (done_k != last + 1 || busy_high_cnt != done_k || end_addr !== exp_addr(b, n - 1)) begin
                errors++;
                $display("FAIL rand%0d_done: done_k=%0d busy=%0d addr=%h want %0d %0d %h", r, done_k,
                         busy_high_cnt, end_addr, last + 1, last + 1, exp_addr(b, n - 1));
            end
            if (mode == 0) begin
                checks++;
                if (first_valid_k != RDL + 1 || last != RDL + n) begin
                    errors++;
                    $display("FAIL rand%0d_rate: first=%0d last=%0d want %0d %0d", r, first_valid_k,
                             last, RDL + 1, RDL + n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_toggle();
        test_wrap();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_reader.md
ROM_READER -- requirements
Module: rom_reader

Interface
REQ-001 Parameter RD_LATENCY, default 1, meaning memory read latency in clk cycles from mem_addr to valid mem_dout (legal 1..2).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of two, >= RD_LATENCY+1).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a burst, sampled only in IDLE.
REQ-006 base_addr  input  32  byte address of first word, bits [1:0] ignored.
REQ-007 word_count  input  16  number of 32-bit words to read.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 mem_addr  output  32  byte address to memory port, word-aligned.
REQ-011 mem_we  output  4  byte write enables, constant 0.
REQ-012 mem_din  output  32  write data, constant 0.
REQ-013 mem_dout  input  32  read data from memory port.
REQ-014 m_data  output  32  stream data, head of output buffer.
REQ-015 m_valid  output  1  stream data valid.
REQ-016 m_ready  input  1  downstream accepts; transfer when m_valid and m_ready.
REQ-017 m_last  output  1  high with the final word of a burst.

Function
REQ-018 FSM states IDLE, READ, DRAIN; IDLE->READ on start with word_count!=0; READ->DRAIN after last read issued; DRAIN->IDLE when final word transferred.
REQ-019 start with word_count==0 in IDLE: done pulses next cycle, busy stays 0, no read issued.
REQ-020 start while busy ignored; base_addr/word_count latched only on accepted start.
REQ-021 In READ one read issued per cycle when (buffer occupancy + reads in flight) < FIFO_DEPTH, counting a same-cycle pop as freeing a slot.
REQ-022 mem_addr = {base_addr[31:2],2'b00} + 4*i for i-th issued read; wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-023 mem_addr holds its last value when no read is issued; a read-valid shift register of length RD_LATENCY tags which cycles' mem_dout are captured.
REQ-024 Captured mem_dout pushed to buffer exactly RD_LATENCY cycles after issue; buffer never overflows, words leave in issue order.
REQ-025 m_valid = buffer non-empty; m_data/m_last stable while m_valid and not m_ready.
REQ-026 m_last asserted only on word index word_count-1.
REQ-027 done pulses in the cycle after the m_last transfer; busy falls in the same cycle done rises.
REQ-028 Throughput one word/cycle with m_ready held high; first m_valid RD_LATENCY+1 cycles after start.

Reset
REQ-029 rst asynchronously forces IDLE, busy=0, done=0, m_valid=0, m_last=0, mem_addr=0, buffer empty, in-flight cleared.
REQ-030 rst mid-burst discards all buffered and in-flight words; no done pulse follows; first start after rst release behaves as from power-up.

Structure
REQ-031 Package rom_reader_pkg holds state encoding, DATA_W=32, ADDR_W=32, ADDR_STEP=4.
REQ-032 Output buffer is sub-module rom_reader_fifo (synchronous FIFO, data+last, push/pop/count, async active-high rst).

Verification
REQ-033 Model memory returns word = address; base_addr=0x4, word_count=3, m_ready=1 -> mem_addr 0x4,0x8,0xC; m_data 0x4,0x8,0xC consecutive; m_last on 0xC; done one cycle later.
REQ-034 word_count=0 start -> done pulse next cycle, busy 0, mem_addr unchanged, m_valid never high.
REQ-035 word_count=8, m_ready toggling 1/0 each cycle -> all 8 words in order, no loss/duplication, occupancy never > FIFO_DEPTH.
REQ-036 base_addr=0xFFFFFFF8, word_count=4 -> mem_addr 0xFFFFFFF8,0xFFFFFFFC,0x00000000,0x00000004.
REQ-037 rst asserted after 2 of 6 words transferred -> outputs zero immediately, no done; new start base 0x10 count 2 returns 0x10,0x14 cleanly.
REQ-038 base_addr=0x7 with start during busy -> second start ignored, reads begin at 0x4, mem_we and mem_din remain 0 throughout.
